// File: rtl/pipo_pkg.sv
// Shared definitions for the parallel register and its downstream frame serializer.
package pipo_pkg;

  localparam int PIPO_WIDTH = 10;
  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } ser_state_t;

endpackage

// File: rtl/piso_frame_serializer.sv
// Frames a parallel word as start / WIDTH data / optional even parity / stop on a
// high-idle serial line, with a valid/ready handshake toward the upstream register.
module piso_frame_serializer
  import pipo_pkg::*;
#(
  parameter int WIDTH     = PIPO_WIDTH,
  parameter bit PARITY_EN = 1'b1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    cnt_q;
  logic             par_q;
  logic             accept;
  logic             ser_d, busy_d, done_d;

  assign in_ready = (state_q == IDLE) || (state_q == STOP);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = START;
      START:   state_d = DATA;
      DATA:    if (cnt_q == CNT_LAST) state_d = PARITY_EN ? PARITY : STOP;
      PARITY:  state_d = STOP;
      STOP:    state_d = accept ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Line values are decided from the state being entered so they register with it.
  always_comb begin
    ser_d  = LINE_IDLE;
    busy_d = 1'b1;
    done_d = 1'b0;
    unique case (state_d)
      IDLE:    busy_d = 1'b0;
      START:   ser_d  = 1'b0;
      DATA:    ser_d  = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
      PARITY:  ser_d  = par_q;
      STOP:    done_d = 1'b1;
      default: busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ser_out <= LINE_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      ser_out <= ser_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Parity is taken from the word at capture; the shift register advances as each bit is sent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      par_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      shreg_q <= in_data;
      par_q   <= ^in_data;
      cnt_q   <= '0;
    end else if (state_d == DATA) begin
      shreg_q <= MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
      if (state_q == DATA) cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: tb/tb_piso_frame_serializer.sv
// Directed + random frames on two serializer configurations, checked bit-by-bit
// against a frame list built from the word with plain arithmetic.
module tb_piso_frame_serializer;

  typedef bit bitq_t[$];

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] da, db;
  logic       va, vb;
  logic       ra, sa, ba, dna;
  logic       rb, sb, bb, dnb;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  piso_frame_serializer dut_a (
    .clk(clk), .reset(reset), .in_data(da), .in_valid(va),
    .in_ready(ra), .ser_out(sa), .busy(ba), .done(dna)
  );

  piso_frame_serializer #(.WIDTH(10), .PARITY_EN(1'b0), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(reset), .in_data(db), .in_valid(vb),
    .in_ready(rb), .ser_out(sb), .busy(bb), .done(dnb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line sequence: start, data in transmit order, optional even parity, stop.
  function automatic bitq_t model(input logic [9:0] w, input bit par, input bit msb);
    bitq_t q;
    int    ones = 0;
    q.push_back(1'b0);
    for (int i = 0; i < 10; i++) begin
      int idx = msb ? 9 - i : i;
      q.push_back(w[idx]);
      ones += int'(w[idx]);
    end
    if (par) q.push_back(bit'(ones % 2));
    q.push_back(1'b1);
    return q;
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [9:0] d);
    if (sel) begin vb = v; db = d; end
    else     begin va = v; da = d; end
  endtask

  task automatic check_idle(input bit sel, input string tag);
    chk({tag, "_ser"},   sel ? sb  : sa,  1);
    chk({tag, "_busy"},  sel ? bb  : ba,  0);
    chk({tag, "_done"},  sel ? dnb : dna, 0);
    chk({tag, "_ready"}, sel ? rb  : ra,  1);
  endtask

  // Caller has presented w with valid; accept happens at the coming rising edge.
  task automatic frame(input bit sel, input logic [9:0] w, input bit noise,
                       input bit chain, input logic [9:0] nw);
    bitq_t e = model(w, !sel, !sel);
    int    last = e.size() - 1;
    for (int i = 0; i <= last; i++) begin
      @(negedge clk);
      chk($sformatf("bit%0d_w%03h", i, w), sel ? sb : sa, e[i]);
      chk("busy",  sel ? bb  : ba,  1);
      chk("done",  sel ? dnb : dna, (i == last) ? 1 : 0);
      chk("ready", sel ? rb  : ra,  (i == last) ? 1 : 0);
      if (!sel && !chain && w inside {10'h000, 10'h3FF, 10'h001, 10'h3FE} && i == 11)
        chk($sformatf("parity_w%03h", w), sa, ($countones(w) % 2));
      if (chain)                    drive(sel, 1'b1, nw);
      else if (noise && i < last)   drive(sel, 1'($urandom), 10'($urandom));
      else                          drive(sel, 1'b0, 10'($urandom));
    end
    if (!chain) begin
      @(negedge clk);
      check_idle(sel, "post");
    end
  endtask

  task automatic send(input bit sel, input logic [9:0] w, input bit noise);
    drive(sel, 1'b1, w);
    chk("ready_pre", sel ? rb : ra, 1);
    frame(sel, w, noise, 1'b0, 10'h0);
  endtask

  initial begin
    reset = 1'b1;
    va = 1'b0; vb = 1'b0; da = '0; db = '0;
    @(negedge clk);
    check_idle(0, "rst_a");
    check_idle(1, "rst_b");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle(0, "idle_a");

    // Single frames on both configurations
    send(0, 10'h2A5, 1'b0);
    send(1, 10'h001, 1'b0);

    // Back-to-back: second word waits through the frame and is taken in STOP
    drive(0, 1'b1, 10'h155);
    frame(0, 10'h155, 1'b0, 1'b1, 10'h0AA);
    frame(0, 10'h0AA, 1'b0, 1'b0, 10'h0);

    // Backpressure with noisy valid/data mid-frame
    send(0, 10'h2A5, 1'b1);
    send(1, 10'h2A5, 1'b1);

    // Parity sweep
    send(0, 10'h000, 1'b0);
    send(0, 10'h3FF, 1'b0);
    send(0, 10'h001, 1'b0);
    send(0, 10'h3FE, 1'b0);

    // Random words, some with noise
    for (int n = 0; n < 8; n++) begin
      send(0, 10'($urandom), 1'($urandom));
      send(1, 10'($urandom), 1'($urandom));
    end

    // Reset in the middle of data bit 4
    drive(0, 1'b1, 10'h3FF);
    @(negedge clk);
    drive(0, 1'b0, 10'h000);
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", ba, 1);
    reset = 1'b1;
    #1;
    chk("rst_async_ser",  sa,  1);
    chk("rst_async_busy", ba,  0);
    chk("rst_async_done", dna, 0);
    chk("rst_async_rdy",  ra,  1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_idle(0, "rst_after");
    end
    // Fresh frame after an aborted one must be complete
    send(0, 10'h2A5, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/piso_frame_serializer.md
Name: piso_frame_serializer

Overview:
Downstream stage of the 10-bit parallel-in/parallel-out register: consumes each parallel word and transmits it as a framed serial bit stream. The frame is a start bit, WIDTH data bits, optional even parity, and a stop bit. A valid/ready handshake lets the upstream register stall while a frame is in flight. Line idles high.

Parameters:
WIDTH, 10, data word width (matches the parallel register width)
PARITY_EN, 1, 1 = insert even-parity bit after data; 0 = no parity bit
MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = bit 0 first

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
in_data  input  WIDTH  parallel word from the upstream register
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  serializer can accept a word this cycle
ser_out  output  1  registered serial line output
busy  output  1  frame in progress (state != IDLE)
done  output  1  high for exactly the cycle ser_out carries the stop bit

Behaviour:
- Reset (async, any time): state=IDLE, ser_out=1, busy=0, done=0, in_ready=1, shift register and bit counter cleared. A frame interrupted by reset is discarded, with no partial stop bit; after release the line stays idle high.
- States: IDLE, START, DATA, PARITY, STOP.
- in_ready is combinational: 1 in IDLE or STOP, else 0.
- Accept = in_valid & in_ready at a rising edge. On accept, in_data is captured into an internal shift register and the block moves to START. Later changes on in_data do not affect the frame.
- ser_out, busy and done are registered and follow state, so they reflect the state entered at the edge:
  - START: ser_out=0, for 1 cycle.
  - DATA: ser_out = current bit, for WIDTH cycles. The bit counter counts 0..WIDTH-1, and the block leaves DATA when the counter reaches WIDTH-1.
  - PARITY: ser_out = XOR of all WIDTH captured bits (even parity), for 1 cycle. Skipped when PARITY_EN=0.
  - STOP: ser_out=1 and done=1, for 1 cycle.
- Latency: accept at edge k gives the start bit after edge k and the first data bit after edge k+1. Frame length is WIDTH+3 cycles (PARITY_EN=1) or WIDTH+2 cycles (PARITY_EN=0).
- Leaving STOP:
  - Accept in the STOP cycle: next state is START. Back-to-back frames have no idle gap.
  - No accept in STOP: next state is IDLE. ser_out stays 1 and busy=0.
- in_valid while in_ready=0: ignored, no capture. Upstream must hold the word until accepted.
- Bit counter width is $clog2(WIDTH) and must be wide enough to reach WIDTH-1. The counter never wraps inside a frame and is cleared on entering START.
- busy=1 in START, DATA, PARITY and STOP.

Decomposition:
- Shared package pipo_pkg holds:
  - localparam PIPO_WIDTH=10, used as the WIDTH default by this block and the parallel register.
  - State enum ser_state_t {IDLE, START, DATA, PARITY, STOP}.
  - localparam LINE_IDLE=1'b1.
- Single module with no sub-module. The shift register, counter and FSM are small enough to stay in one file.

Test Plan:
1. Reset mid-frame: accept 10'h3FF, assert reset at data bit 4 -> ser_out=1, busy=0, done=0 immediately (asynchronous). After release, ser_out stays 1 with no stray bits.
2. Single frame, defaults: present 10'h2A5 with in_valid for one cycle -> ser_out sequence 0, 1,0,1,0,1,0,0,1,0,1, parity 1, stop 1; 13 cycles total; done high only in the stop cycle; returns to IDLE.
3. PARITY_EN=0, MSB_FIRST=0, word 10'h001 -> ser_out sequence 0, 1,0,0,0,0,0,0,0,0,0, stop 1; 12 cycles total; no parity bit present.
4. Back-to-back: hold in_valid with 10'h155 then 10'h0AA -> second accept occurs in the STOP cycle of the first frame; the second start bit immediately follows the first stop bit with no idle cycle.
5. Backpressure: toggle in_valid and change in_data every cycle during a frame of 10'h2A5 -> transmitted bits unchanged; in_ready=0 from START through PARITY.
6. Parity sweep: words 10'h000, 10'h3FF, 10'h001, 10'h3FE -> parity bits 0, 0, 1, 1 respectively.
